// File: rtl/tc0260dar_fifo_if.sv
// tc0260dar_fifo_if: 68000-side palette bus (chip select, address, data, strobes, dtack).
// The master modport is the CPU side; the slave modport is the palette chip.
interface tc0260dar_fifo_if #(
    parameter int AW = 14
);
    logic          cs;
    logic [AW-1:0] ma;
    logic [15:0]   md_in;
    logic [15:0]   md_out;
    logic          rw_n;
    logic          uds_n;
    logic          lds_n;
    logic          dtack_n;

    modport master (
        output cs, ma, md_in, rw_n, uds_n, lds_n,
        input  md_out, dtack_n
    );

    modport slave (
        input  cs, ma, md_in, rw_n, uds_n, lds_n,
        output md_out, dtack_n
    );
endinterface

// File: rtl/tc0260dar_fifo.sv
// tc0260dar_fifo: palette RAM arbiter and colour DAC front-end.
// CPU writes are posted into a small FIFO and drained into the single-port palette RAM
// during blanking (or at any time when accmode=1); CPU reads wait for the FIFO to empty.
// Optional feature macro: TC0260DAR_FADE_EN adds fade[7:0] and a brightness stage
// (video latency becomes two ce_pixel).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | video owns the RAM, ra follows im
// DRAIN  | one queued CPU write per ce_double slot (ra/rd_out/strobes from FIFO head)
// RADDR  | CPU read address presented to the RAM
// RDATA  | RAM data captured into md_out, read acknowledged
module tc0260dar_fifo #(
    parameter int AW    = 14,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pixel,
    input  logic              ce_double,
    input  logic [1:0]        fmt,
    input  logic              accmode,
    tc0260dar_fifo_if.slave   bus,
    input  logic              hblank_n,
    input  logic              vblank_n,
    input  logic [AW-1:0]     im,
    output logic [7:0]        video_r,
    output logic [7:0]        video_g,
    output logic [7:0]        video_b,
    output logic [AW-1:0]     ra,
    input  logic [15:0]       rd_in,
    output logic [15:0]       rd_out,
    output logic              rwel_n,
    output logic              rweh_n,
    output logic              fifo_full
`ifdef TC0260DAR_FADE_EN
    ,
    input  logic [7:0]        fade
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 18;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RADDR = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    logic [1:0]    state;
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          fifo_empty;
    logic          busy;
    logic          push;
    logic          pop;
    logic          acked;
    logic [15:0]   md_reg;
    logic [7:0]    exp_r, exp_g, exp_b;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          show;

    assign busy       = ~accmode & hblank_n & vblank_n;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign head       = fifo_mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a write waiting on a full FIFO is taken then.
    assign pop  = ce_double & (state == ST_DRAIN) & ~fifo_empty;
    assign push = bus.cs & ~bus.rw_n & ~acked & (~fifo_full | pop);

    assign bus.md_out  = md_reg;
    assign bus.dtack_n = ~(acked & bus.cs);

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.ma, bus.md_in, bus.uds_n, bus.lds_n};
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // RAM slot sequencer; a drain slot that has started always finishes its write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_double && !busy) begin
                        if (!fifo_empty) begin
                            state <= ST_DRAIN;
                        end else if (bus.cs && bus.rw_n && !acked) begin
                            state <= ST_RADDR;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ce_double && (busy || count_next == '0)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RADDR: begin
                    if (!bus.cs) begin
                        state <= ST_IDLE;
                    end else if (ce_double) begin
                        state <= ST_RDATA;
                    end
                end
                default: begin
                    if (!bus.cs || ce_double) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // CPU acknowledge and read data; an ack is held until the CPU releases cs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acked  <= 1'b0;
            md_reg <= '0;
        end else begin
            if (!bus.cs) begin
                acked <= 1'b0;
            end else if (push) begin
                acked <= 1'b1;
            end else if (state == ST_RDATA && ce_double) begin
                acked  <= 1'b1;
                md_reg <= rd_in;
            end
        end
    end

    // RAM port mux; enables are gated by state so reset releases them immediately.
    always_comb begin
        ra     = im;
        rd_out = head[17:2];
        rweh_n = 1'b1;
        rwel_n = 1'b1;
        case (state)
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    ra     = head[EW-1 -: AW];
                    rweh_n = head[1];
                    rwel_n = head[0];
                end
            end
            ST_RADDR, ST_RDATA: ra = bus.ma;
            default: ;
        endcase
    end

    // Colour expansion of the palette word for the selected format (11 behaves as 00).
    always_comb begin
        exp_r = {rd_in[15:12], rd_in[15:12]};
        exp_g = {rd_in[11:8],  rd_in[11:8]};
        exp_b = {rd_in[7:4],   rd_in[7:4]};
        case (fmt)
            2'b01: begin
                exp_r = {rd_in[14:10], rd_in[14:12]};
                exp_g = {rd_in[9:5],   rd_in[9:7]};
                exp_b = {rd_in[4:0],   rd_in[4:2]};
            end
            2'b10: begin
                exp_r = {rd_in[15:12], rd_in[3], rd_in[15:13]};
                exp_g = {rd_in[11:8],  rd_in[2], rd_in[11:9]};
                exp_b = {rd_in[7:4],   rd_in[1], rd_in[7:5]};
            end
            default: ;
        endcase
    end

    assign show = hblank_n & vblank_n & (state == ST_IDLE);

    // First pixel stage: black whenever blanked or the RAM is serving the CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_r <= '0;
            pix_g <= '0;
            pix_b <= '0;
        end else if (ce_pixel) begin
            pix_r <= show ? exp_r : 8'd0;
            pix_g <= show ? exp_g : 8'd0;
            pix_b <= show ? exp_b : 8'd0;
        end
    end

`ifdef TC0260DAR_FADE_EN
    logic [8:0] fade_mul;
    assign fade_mul = {1'b0, fade} + 9'd1;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] m);
        logic [16:0] p;
        p = {9'd0, c} * {8'd0, m};
        return p[15:8];
    endfunction

    // Brightness stage: c*(fade+1)>>8, so fade=255 passes the colour unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_r <= '0;
            video_g <= '0;
            video_b <= '0;
        end else if (ce_pixel) begin
            video_r <= scale(pix_r, fade_mul);
            video_g <= scale(pix_g, fade_mul);
            video_b <= scale(pix_b, fade_mul);
        end
    end
`else
    assign video_r = pix_r;
    assign video_g = pix_g;
    assign video_b = pix_b;
`endif
endmodule

// File: tb/tb_tc0260dar_fifo.sv
// tb_tc0260dar_fifo: directed bench for the palette arbiter with a behavioural palette RAM.
`timescale 1ns/1ps
module tb_tc0260dar_fifo;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    ce_cnt = 2'd0;
    logic          ce_pixel, ce_double;
    logic [1:0]    fmt;
    logic          accmode, hblank_n, vblank_n;
    logic [AW-1:0] im;
    logic [7:0]    video_r, video_g, video_b;
    logic [AW-1:0] ra;
    logic [15:0]   rd_in, rd_out, rd_q, rd_force;
    logic          rd_sel;
    logic          rwel_n, rweh_n, fifo_full;
`ifdef TC0260DAR_FADE_EN
    logic [7:0]    fade;
`endif

    tc0260dar_fifo_if #(.AW(AW)) bus ();

    tc0260dar_fifo #(.AW(AW), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_pixel  (ce_pixel),
        .ce_double (ce_double),
        .fmt       (fmt),
        .accmode   (accmode),
        .bus       (bus),
        .hblank_n  (hblank_n),
        .vblank_n  (vblank_n),
        .im        (im),
        .video_r   (video_r),
        .video_g   (video_g),
        .video_b   (video_b),
        .ra        (ra),
        .rd_in     (rd_in),
        .rd_out    (rd_out),
        .rwel_n    (rwel_n),
        .rweh_n    (rweh_n),
        .fifo_full (fifo_full)
`ifdef TC0260DAR_FADE_EN
        ,
        .fade      (fade)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
    assign ce_double = ce_cnt[0];
    assign ce_pixel  = &ce_cnt;
    assign rd_in     = rd_sel ? rd_force : rd_q;

    // Palette RAM model: one ce_double read latency, byte-lane writes, write log.
    int          cyc = 0;
    logic [15:0] mem [256];
    logic [13:0] wlog_addr [64];
    logic [15:0] wlog_data [64];
    int          wlog_time [64];
    int          wr_cnt = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ce_double) begin
            rd_q <= mem[ra[7:0]];
            if (!rweh_n) mem[ra[7:0]][15:8] <= rd_out[15:8];
            if (!rwel_n) mem[ra[7:0]][7:0]  <= rd_out[7:0];
            if (!rweh_n || !rwel_n) begin
                if (wr_cnt < 64) begin
                    wlog_addr[wr_cnt] <= ra;
                    wlog_data[wr_cnt] <= rd_out;
                    wlog_time[wr_cnt] <= cyc;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (!rwel_n) lo_cnt <= lo_cnt + 1;
            if (!rweh_n) hi_cnt <= hi_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [15:0] d,
                             input logic u, input logic l, output int lat);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw_n = 1'b0; bus.ma = a; bus.md_in = d;
        bus.uds_n = u; bus.lds_n = l;
        lat = 0;
        while (bus.dtack_n && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.cs = 1'b0; bus.rw_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
    endtask

    task automatic wait_writes(input int target, input string nm);
        int t = 0;
        while (wr_cnt < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(nm, wr_cnt, target);
    endtask

    // Returns one negedge after the next posedge at which ce_pixel is high.
    task automatic wait_pix();
        int t = 0;
        while (!ce_pixel && t < 8) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  fmt;
        logic [15:0] rd;
        logic        hb;
        logic        vb;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    vec_t vecs [12];
    int   nvec = 0;

    task automatic add_vec(input string nm, input logic [1:0] f, input logic [15:0] d,
                           input logic hb, input logic vb,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vecs[nvec].name = nm; vecs[nvec].fmt = f; vecs[nvec].rd = d;
        vecs[nvec].hb = hb; vecs[nvec].vb = vb;
        vecs[nvec].r = r; vecs[nvec].g = g; vecs[nvec].b = b;
        nvec++;
    endtask

    initial begin
        int lat;
        int base;
        int t;
        int lo0, hi0;
        int ack_cyc;
        logic stuck;
        logic seen;

        add_vec("f01 white",   2'b01, 16'h7FFF, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        add_vec("f00 red",     2'b00, 16'hF000, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        add_vec("f00 mixed",   2'b00, 16'hA5C3, 1'b1, 1'b1, 8'hAA, 8'h55, 8'hCC);
        add_vec("f11 as 00",   2'b11, 16'hF000, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        add_vec("f01 mixed",   2'b01, 16'h4101, 1'b1, 1'b1, 8'h84, 8'h42, 8'h08);
        add_vec("f10 lsb set", 2'b10, 16'hF00E, 1'b1, 1'b1, 8'hFF, 8'h08, 8'h08);
        add_vec("f10 lsb clr", 2'b10, 16'h8420, 1'b1, 1'b1, 8'h84, 8'h42, 8'h21);
        add_vec("hblank",      2'b01, 16'h7FFF, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        add_vec("vblank",      2'b01, 16'h7FFF, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

        reset_n = 1'b0; fmt = 2'b00; accmode = 1'b0; hblank_n = 1'b1; vblank_n = 1'b1;
        im = 14'h0123; rd_force = 16'h0000; rd_sel = 1'b0;
        bus.cs = 1'b0; bus.rw_n = 1'b1; bus.ma = '0; bus.md_in = '0;
        bus.uds_n = 1'b1; bus.lds_n = 1'b1;
`ifdef TC0260DAR_FADE_EN
        fade = 8'hFF;
`endif
        wait_clk(3);
        check("rst dtack_n", bus.dtack_n, 1'b1);
        check("rst rwel_n", rwel_n, 1'b1);
        check("rst rweh_n", rweh_n, 1'b1);
        check("rst md_out", bus.md_out, 16'h0000);
        check("rst video", {video_r, video_g, video_b}, 24'h0);
        check("rst fifo_full", fifo_full, 1'b0);
        check("rst ra=im", ra, 14'h0123);
        reset_n = 1'b1;
        wait_clk(2);

        // Posted writes in active display, drained in blanking.
        base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            cpu_write(14'h040 + 14'(i), 16'h1000 + 16'(i), 1'b0, 1'b0, lat);
            check("t1 ack within 2 clk", (lat >= 1 && lat <= 2), 1'b1);
        end
        wait_clk(10);
        check("t1 ram untouched in display", wr_cnt - base, 0);
        hblank_n = 1'b0;
        wait_writes(base + 3, "t1 drained count");
        for (int i = 0; i < 3; i++) begin
            check("t1 drain addr", wlog_addr[base + i], 14'h040 + 14'(i));
            check("t1 drain data", wlog_data[base + i], 16'h1000 + 16'(i));
        end
        check("t1 slot spacing 1", wlog_time[base + 1] - wlog_time[base], 2);
        check("t1 slot spacing 2", wlog_time[base + 2] - wlog_time[base + 1], 2);
        hblank_n = 1'b1;
        wait_clk(4);

        // Full FIFO holds off the fifth write until the first pop.
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            cpu_write(14'h050 + 14'(i), 16'h5000 + 16'(i), 1'b0, 1'b0, lat);
            check("t2 ack while filling", (lat >= 1 && lat <= 2), 1'b1);
        end
        check("t2 fifo_full", fifo_full, 1'b1);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw_n = 1'b0; bus.ma = 14'h054; bus.md_in = 16'h5004;
        bus.uds_n = 1'b0; bus.lds_n = 1'b0;
        stuck = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!bus.dtack_n) stuck = 1'b0;
        end
        check("t2 no ack while full", stuck, 1'b1);
        hblank_n = 1'b0;
        t = 0;
        while (bus.dtack_n && t < 100) begin
            @(negedge clk);
            t++;
        end
        ack_cyc = cyc;
        check("t2 fifth write acked", bus.dtack_n, 1'b0);
        check("t2 ack on first pop", ack_cyc, wlog_time[base] + 1);
        bus.cs = 1'b0; bus.rw_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
        wait_writes(base + 5, "t2 drained count");
        for (int i = 0; i < 5; i++) begin
            check("t2 order addr", wlog_addr[base + i], 14'h050 + 14'(i));
            check("t2 order data", wlog_data[base + i], 16'h5000 + 16'(i));
        end
        check("t2 fifo not full", fifo_full, 1'b0);
        hblank_n = 1'b1;
        wait_clk(4);

        // Read after write returns the new data only once the FIFO has drained.
        base = wr_cnt;
        cpu_write(14'h010, 16'h1234, 1'b0, 1'b0, lat);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw_n = 1'b1; bus.ma = 14'h010;
        stuck = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.dtack_n) stuck = 1'b0;
        end
        check("t3 read held in display", stuck, 1'b1);
        hblank_n = 1'b0;
        t = 0;
        while (bus.dtack_n && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t3 read acked", bus.dtack_n, 1'b0);
        check("t3 drained before ack", wr_cnt - base, 1);
        check("t3 md_out", bus.md_out, 16'h1234);
        bus.cs = 1'b0;
        wait_clk(3);
        check("t3 dtack_n high after cs", bus.dtack_n, 1'b1);

        // Read aborted by cs dropping before data: no ack, md_out kept.
        @(negedge clk);
        bus.cs = 1'b1; bus.rw_n = 1'b1; bus.ma = 14'h041;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (!bus.dtack_n) seen = 1'b1;
        end
        bus.cs = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (!bus.dtack_n) seen = 1'b1;
        end
        check("t3 abort no dtack", seen, 1'b0);
        check("t3 abort md_out kept", bus.md_out, 16'h1234);
        check("t3 abort ra=im", ra, im);
        hblank_n = 1'b1;

        // Colour formats and blanking.
        rd_sel = 1'b1;
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            fmt = vecs[i].fmt; rd_force = vecs[i].rd;
            hblank_n = vecs[i].hb; vblank_n = vecs[i].vb;
            wait_clk(10);
            check({vecs[i].name, " r"}, video_r, vecs[i].r);
            check({vecs[i].name, " g"}, video_g, vecs[i].g);
            check({vecs[i].name, " b"}, video_b, vecs[i].b);
        end

        // Video latency from RAM data change.
        @(negedge clk);
        fmt = 2'b00; rd_force = 16'h0000; hblank_n = 1'b1; vblank_n = 1'b1;
        wait_clk(10);
        rd_force = 16'hF000;
        wait_pix();
`ifdef TC0260DAR_FADE_EN
        check("lat after 1 pix", video_r, 8'h00);
        wait_pix();
        check("lat after 2 pix", video_r, 8'hFF);
        fade = 8'h7F;
        wait_clk(12);
        check("t6 fade 7F r", video_r, 8'h7F);
        check("t6 fade 7F g", video_g, 8'h00);
        fade = 8'h00;
        wait_clk(12);
        check("t6 fade 0 r", video_r, 8'h00);
        fade = 8'hFF;
`else
        check("lat after 1 pix", video_r, 8'hFF);
`endif
        rd_sel = 1'b0;

        // Byte strobes: low byte only.
        hblank_n = 1'b0;
        base = wr_cnt;
        cpu_write(14'h020, 16'hAAAA, 1'b0, 1'b0, lat);
        wait_writes(base + 1, "t5 word write");
        lo0 = lo_cnt; hi0 = hi_cnt;
        cpu_write(14'h020, 16'h1155, 1'b1, 1'b0, lat);
        wait_writes(base + 2, "t5 byte write");
        wait_clk(2);
        check("t5 rwel pulses", lo_cnt - lo0, 1);
        check("t5 rweh pulses", hi_cnt - hi0, 0);
        check("t5 merged word", mem[8'h20], 16'hAA55);

        // Reset in the middle of a drain.
        hblank_n = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 3; i++) cpu_write(14'h060 + 14'(i), 16'h6000 + 16'(i), 1'b0, 1'b0, lat);
        base = wr_cnt;
        @(negedge clk);
        hblank_n = 1'b0;
        t = 0;
        while (wr_cnt == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t5 drain in progress", rwel_n, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t5 rwel_n async high", rwel_n, 1'b1);
        check("t5 rweh_n async high", rweh_n, 1'b1);
        check("t5 fifo cleared", fifo_full, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clk(20);
        check("t5 no writes after reset", wr_cnt - base, 1);
        check("t5 first write addr", wlog_addr[base], 14'h060);
        check("t5 ra=im after reset", ra, im);
        check("t5 md_out reset", bus.md_out, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
